// File: rtl/sobel_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sobel_job_ctrl
// Purpose  : CSR-mapped job controller for the Sobel HLS core: ap_start/ap_done
//            handshake, run-length cycle counter, watchdog with core abort.
// Revision : 1.0
// ============================================================================
module sobel_job_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0010,
    parameter int unsigned ABORT_CYCLES = 8,
    parameter logic [31:0] TIMEOUT_RST  = 32'd0
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        ap_start_o,
    output logic        ap_rst_o,
    input  logic        ap_ready_i,
    input  logic        ap_done_i,
    input  logic        ap_idle_i,
    output logic        mem_lock_o,
    output logic        irq_o
);

    localparam int unsigned    ABW     = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;
    localparam logic [ABW-1:0] AB_LAST = ABW'(ABORT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_FIN   = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [31:0]    cycles_q, cycles_d;
    logic [31:0]    tmo_lim_q, tmo_lim_d;
    logic           done_q, done_d;
    logic           tmo_q, tmo_d;
    logic           serr_q, serr_d;
    logic [ABW-1:0] ab_cnt_q, ab_cnt_d;
    logic           irq_q, irq_d;
    logic           resp_q;
    logic [31:0]    rdata_q;
    logic [31:0]    rd_val;

    logic        hit, wr_ctrl, wr_tmo, rd_req;
    logic        cmd_start, cmd_clr, cmd_abort;
    logic        busy, tmo_hit, core_done;
    logic [31:0] cnt_inc;

    // Unaligned addresses are treated as outside the window.
    assign hit       = bus_req_i && (bus_addr_bi[31:4] == BASE_ADDR[31:4]) && (bus_addr_bi[1:0] == 2'b00);
    assign wr_ctrl   = hit && bus_we_i && (bus_addr_bi[3:2] == 2'd0);
    assign wr_tmo    = hit && bus_we_i && (bus_addr_bi[3:2] == 2'd3);
    assign rd_req    = hit && !bus_we_i;
    assign cmd_start = wr_ctrl && bus_wdata_bi[0];
    assign cmd_clr   = wr_ctrl && bus_wdata_bi[1];
    assign cmd_abort = wr_ctrl && bus_wdata_bi[2];

    assign busy      = (state_q == ST_START) || (state_q == ST_RUN) || (state_q == ST_ABORT);
    assign cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    assign tmo_hit   = (tmo_lim_q != 32'd0) && (cnt_q == tmo_lim_q);
    assign core_done = ap_done_i && ((state_q == ST_RUN) || ap_ready_i);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cycles_d  = cycles_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        serr_d    = serr_q;
        ab_cnt_d  = ab_cnt_q;
        irq_d     = 1'b0;
        tmo_lim_d = wr_tmo ? bus_wdata_bi : tmo_lim_q;

        // Clear is applied first so a combined clear+start still launches the job.
        if (cmd_clr) begin
            done_d = 1'b0;
            tmo_d  = 1'b0;
            serr_d = 1'b0;
        end

        if (cmd_abort) begin
            state_d  = ST_ABORT;
            ab_cnt_d = AB_LAST;
        end else begin
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    state_d = ST_IDLE;
                    if (cmd_start) begin
                        state_d = ST_START;
                        cnt_d   = 32'd0;
                        done_d  = 1'b0;
                        tmo_d   = 1'b0;
                    end
                end
                ST_START, ST_RUN: begin
                    cnt_d = cnt_inc;
                    if (cmd_start) begin
                        serr_d = 1'b1;
                    end
                    if (tmo_hit) begin
                        state_d  = ST_ABORT;
                        ab_cnt_d = AB_LAST;
                        tmo_d    = 1'b1;
                        irq_d    = 1'b1;
                        cycles_d = cnt_q;
                    end else if (core_done) begin
                        state_d  = ST_FIN;
                        done_d   = 1'b1;
                        irq_d    = 1'b1;
                        cycles_d = cnt_inc;
                    end else if ((state_q == ST_START) && ap_ready_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_ABORT: begin
                    if (cmd_start) begin
                        serr_d = 1'b1;
                    end
                    if (ab_cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        ab_cnt_d = ab_cnt_q - ABW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (bus_addr_bi[3:2])
            2'd1:    rd_val = {27'd0, serr_q, ap_idle_i, tmo_q, done_q, busy};
            2'd2:    rd_val = cycles_q;
            2'd3:    rd_val = tmo_lim_q;
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 32'd0;
            cycles_q  <= 32'd0;
            tmo_lim_q <= TIMEOUT_RST;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            serr_q    <= 1'b0;
            ab_cnt_q  <= '0;
            irq_q     <= 1'b0;
            resp_q    <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cycles_q  <= cycles_d;
            tmo_lim_q <= tmo_lim_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            serr_q    <= serr_d;
            ab_cnt_q  <= ab_cnt_d;
            irq_q     <= irq_d;
            resp_q    <= rd_req;
            rdata_q   <= rd_req ? rd_val : 32'd0;
        end
    end

    // Handshake outputs decode straight from the async-reset state register.
    assign ap_start_o   = (state_q == ST_START);
    assign ap_rst_o     = (state_q == ST_ABORT);
    assign mem_lock_o   = busy;
    assign irq_o        = irq_q;
    assign bus_ack_o    = bus_req_i;
    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_job_ctrl
// Purpose  : Self-checking bench for sobel_job_ctrl with a job-level reference model.
// Revision : 1.0
// ============================================================================
module tb_sobel_job_ctrl;

    localparam logic [31:0] BASE   = 32'h0000_0010;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_CYC  = BASE + 32'd8;
    localparam logic [31:0] A_TMO  = BASE + 32'd12;
    localparam int unsigned NAB    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        ready = 1'b0, done = 1'b0, idle = 1'b0;
    logic        bus_ack_o, bus_resp_o, ap_start_o, ap_rst_o, mem_lock_o, irq_o;
    logic [31:0] bus_rdata_bo;

    int total = 0;
    int bad   = 0;

    // Job-level reference state: sticky flags and registers as seen by software.
    logic        m_done = 1'b0, m_tmo = 1'b0, m_serr = 1'b0;
    logic [31:0] m_cycles = 32'd0;

    sobel_job_ctrl dut (
        .clk_i        (clk),
        .arst_i       (rst),
        .bus_req_i    (req),
        .bus_we_i     (we),
        .bus_addr_bi  (addr),
        .bus_wdata_bi (wdata),
        .bus_ack_o    (bus_ack_o),
        .bus_resp_o   (bus_resp_o),
        .bus_rdata_bo (bus_rdata_bo),
        .ap_start_o   (ap_start_o),
        .ap_rst_o     (ap_rst_o),
        .ap_ready_i   (ready),
        .ap_done_i    (done),
        .ap_idle_i    (idle),
        .mem_lock_o   (mem_lock_o),
        .irq_o        (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        chk("rd_resp", bus_resp_o, 1);
        d = bus_rdata_bo;
        @(negedge clk);
        chk("rd_resp_end", bus_resp_o, 0);
    endtask

    task automatic bus_read_miss(input logic [31:0] a);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        chk("miss_resp", bus_resp_o, 0);
        chk("miss_rdata", bus_rdata_bo, 0);
    endtask

    task automatic check_status(input string tag, input logic idl);
        logic [31:0] rd;
        idle = idl;
        bus_read(A_STAT, rd);
        chk(tag, rd, {27'd0, m_serr, idl, m_tmo, m_done, 1'b0});
    endtask

    task automatic check_cycles(input string tag);
        logic [31:0] rd;
        bus_read(A_CYC, rd);
        chk(tag, rd, m_cycles);
    endtask

    // One job: core raises ap_ready r cycles after START entry and ap_done d cycles
    // after that. pv=1 pokes a second start mid-job, pv=4 pokes an abort.
    task automatic run_job(input int unsigned r, input int unsigned d, input int unsigned t,
                           input logic [31:0] sv, input logic [31:0] pv);
        int unsigned e_done, e, kind, p, len;
        int unsigned sc, rc, lc, ic, ik;
        int unsigned x_sc, x_lc, x_rc, x_ic;
        bus_write(A_TMO, t);
        e_done = r + d;
        if (t != 0 && t < e_done) begin
            kind = 1; e = t;
        end else begin
            kind = 0; e = e_done;
        end
        if (r + 1 <= e) p = $urandom_range(e, r + 1);
        else            p = $urandom_range(e, 0);
        if (pv == 32'd4) begin
            kind = 2; e = p;
        end
        if (sv[1]) begin
            m_done = 1'b0; m_tmo = 1'b0; m_serr = 1'b0;
        end
        m_done = 1'b0; m_tmo = 1'b0;
        idle = 1'b0;
        bus_write(A_CTRL, sv);
        sc = 0; rc = 0; lc = 0; ic = 0; ik = 0;
        len = e + NAB + 4;
        for (int k = 0; k < int'(len); k++) begin
            if (ap_start_o) sc++;
            if (ap_rst_o)   rc++;
            if (mem_lock_o) lc++;
            if (irq_o) begin ic++; ik = k; end
            ready = (k == int'(r));
            done  = (k == int'(e_done));
            if (pv != 0 && k == int'(p)) begin
                req = 1'b1; we = 1'b1; addr = A_CTRL; wdata = pv;
            end else begin
                req = 1'b0; we = 1'b0;
            end
            @(negedge clk);
        end
        ready = 1'b0; done = 1'b0; req = 1'b0; we = 1'b0;

        x_sc = ((r < e) ? r : e) + 1;
        x_lc = (kind == 0) ? e + 1 : e + 1 + NAB;
        x_rc = (kind == 0) ? 0 : NAB;
        x_ic = (kind == 2) ? 0 : 1;
        chk("start_cycles", sc, x_sc);
        chk("lock_cycles", lc, x_lc);
        chk("aprst_cycles", rc, x_rc);
        chk("irq_pulses", ic, x_ic);
        if (x_ic == 1) chk("irq_cycle", ik, e + 1);

        if (kind == 0) begin m_done = 1'b1; m_cycles = e_done + 1; end
        if (kind == 1) begin m_tmo = 1'b1;  m_cycles = t; end
        if (pv == 32'd1) m_serr = 1'b1;
        check_status("job_status", 1'($urandom_range(1, 0)));
        check_cycles("job_cycles");
    endtask

    initial begin
        logic [31:0] rd;
        int unsigned r, d, t, sel;
        logic [31:0] sv, pv;

        // Power-up reset
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ap_start", ap_start_o, 0);
        chk("rst_ap_rst", ap_rst_o, 0);
        chk("rst_lock", mem_lock_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_resp", bus_resp_o, 0);
        chk("rst_rdata", bus_rdata_bo, 0);
        rst = 1'b0;
        @(negedge clk);
        check_status("rst_status", 1'b0);
        check_cycles("rst_cycles");
        bus_read(A_TMO, rd);
        chk("rst_timeout", rd, 0);

        // Bus decode: ack, out-of-window, unaligned, timeout register
        req = 1'b1; addr = 32'h20; #1;
        chk("ack_hi", bus_ack_o, 1);
        req = 1'b0; #1;
        chk("ack_lo", bus_ack_o, 0);
        @(negedge clk);
        bus_read_miss(32'h20);
        bus_read_miss(BASE + 32'd5);
        bus_write(32'h20, 32'd1);
        chk("oow_no_start", ap_start_o, 0);
        bus_write(BASE + 32'd1, 32'd1);
        chk("unaligned_no_start", mem_lock_o, 0);
        bus_write(A_TMO, 32'd5);
        bus_read(A_TMO, rd);
        chk("timeout_rw", rd, 5);
        bus_read(A_CTRL, rd);
        chk("ctrl_reads_0", rd, 0);

        // Normal job: ready after 2 cycles, done 50 later
        run_job(2, 50, 0, 32'd1, 32'd0);
        check_status("t1_status_0a", 1'b1);
        // ready and done together on the first START cycle
        run_job(0, 0, 0, 32'd1, 32'd0);
        // Watchdog: core never finishes
        run_job(3, 1000, 20, 32'd1, 32'd0);
        // Start while busy, then clear
        run_job(1, 10, 0, 32'd1, 32'd1);
        bus_write(A_CTRL, 32'd2);
        m_done = 1'b0; m_tmo = 1'b0; m_serr = 1'b0;
        check_status("clr_status", 1'b0);
        // User abort mid-job
        run_job(4, 30, 0, 32'd1, 32'd4);

        // Randomized jobs
        for (int i = 0; i < 30; i++) begin
            r   = $urandom_range(6, 0);
            d   = $urandom_range(40, 0);
            t   = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(50, 1);
            if (t == r + d) t = t + 1;
            sv  = ($urandom_range(1, 0) == 0) ? 32'd1 : 32'd3;
            sel = $urandom_range(2, 0);
            pv  = (sel == 0) ? 32'd0 : ((sel == 1) ? 32'd1 : 32'd4);
            run_job(r, d, t, sv, pv);
            if ($urandom_range(3, 0) == 0) begin
                bus_write(A_CTRL, 32'd2);
                m_done = 1'b0; m_tmo = 1'b0; m_serr = 1'b0;
                check_status("rand_clr", 1'($urandom_range(1, 0)));
            end
        end

        // Async reset during START: ap_start must drop without a clock edge
        bus_write(A_CTRL, 32'd1);
        #1;
        chk("pre_arst_start", ap_start_o, 1);
        rst = 1'b1;
        #1;
        chk("arst_start_drop", ap_start_o, 0);
        chk("arst_lock_drop", mem_lock_o, 0);
        @(negedge clk);
        rst = 1'b0;
        m_done = 1'b0; m_tmo = 1'b0; m_serr = 1'b0; m_cycles = 32'd0;
        @(negedge clk);

        // Async reset during RUN after a completed job left flags set
        run_job(1, 3, 0, 32'd1, 32'd1);
        bus_write(A_CTRL, 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        chk("run_lock", mem_lock_o, 1);
        chk("run_no_start", ap_start_o, 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_run_lock", mem_lock_o, 0);
        chk("arst_run_start", ap_start_o, 0);
        chk("arst_run_aprst", ap_rst_o, 0);
        @(negedge clk);
        rst = 1'b0;
        m_done = 1'b0; m_tmo = 1'b0; m_serr = 1'b0; m_cycles = 32'd0;
        @(negedge clk);
        check_status("arst_status", 1'b0);
        check_cycles("arst_cycles");
        bus_read(A_TMO, rd);
        chk("arst_timeout", rd, 0);
        run_job(2, 5, 0, 32'd1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
